bcd_display_receiver: RTL
=========================

BCD_DISPLAY_RECEIVER -- requirements
Module: bcd_display_receiver

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000: consecutive clocks a synchronized BCD code SHALL hold before the block accepts it; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 A  input  1  BCD bit 0 (LSB) from the external counting board; asynchronous to clk.
REQ-005 B  input  1  BCD bit 1; asynchronous.
REQ-006 C  input  1  BCD bit 2; asynchronous.
REQ-007 D  input  1  BCD bit 3 (MSB); asynchronous.
REQ-008 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-009 seg  output  7  seven-segment drive, active-low, seg[0]=a ... seg[6]=g.
REQ-010 digit  output  4  last accepted legal BCD digit.
REQ-011 digit_valid  output  1  high once any legal digit has been accepted since reset.
REQ-012 update  output  1  one-cycle pulse on every accepted code change.
REQ-013 wrap  output  1  one-cycle pulse when an accepted 0 directly follows an accepted 9.
REQ-014 step_count  output  8  count of in-sequence steps accepted.
REQ-015 err_illegal  output  1  sticky: a code 10..15 was accepted.
REQ-016 err_seq  output  1  sticky: an accepted legal digit was not (previous legal + 1) mod 10.

Function
REQ-017 {D,C,B,A} SHALL pass through a two-flop synchronizer before any other use.
REQ-018 Filter: a stability counter SHALL restart whenever the synchronized code changes; when it reaches STABLE_CYCLES with the code differing from the currently accepted code, that code SHALL be accepted.
REQ-019 A code equal to the currently accepted code SHALL never produce update.
REQ-020 Latency: update, seg and digit SHALL change exactly 2 + STABLE_CYCLES clocks after a clean input edge.
REQ-021 Pulses shorter than STABLE_CYCLES clocks at the synchronizer output SHALL be ignored entirely.
REQ-022 FSM states: WAIT_FIRST (no legal digit accepted since reset) and TRACK; WAIT_FIRST -> TRACK on first accepted legal code; no transition back except reset.
REQ-023 In WAIT_FIRST the first legal digit SHALL be accepted without a sequence check and without incrementing step_count.
REQ-024 In TRACK, an accepted legal digit equal to (last legal + 1) mod 10 SHALL increment step_count by 1, wrapping 255 -> 0; any other legal digit SHALL set err_seq and leave step_count unchanged.
REQ-025 An accepted illegal code (10..15) SHALL set err_illegal, drive seg to dash (g only: 7'b0111111), leave digit, step_count and FSM state unchanged.
REQ-026 The legal digit after an illegal code SHALL be sequence-checked against the last legal digit.
REQ-027 Legal digits SHALL drive standard patterns (0 = 7'b1000000, 1 = 7'b1111001, ..., 9 = 7'b0010000); seg SHALL be registered.
REQ-028 err_clr clears both sticky flags next clock; if an error sets in the same cycle, the set SHALL win.
REQ-029 wrap SHALL only pulse in TRACK and coincide with the update pulse.

Reset
REQ-030 While rst_n is low: synchronizer flops, filter counter and accepted code = 0; FSM = WAIT_FIRST; seg = 7'b1111111 (blank); digit = 0; digit_valid, update, wrap, err_illegal, err_seq = 0; step_count = 0.
REQ-031 Reset asserted mid-filter SHALL discard the pending candidate; after release the current input needs the full 2 + STABLE_CYCLES clocks.

Structure
REQ-032 Shared package SHALL hold the ten seven-segment patterns, the blank and dash constants and the FSM state encoding.
REQ-033 Synchronizer plus stability filter SHALL be one sub-module, bcd_input_filter, outputting accepted code and an accept strobe.

Verification (STABLE_CYCLES = 4)
REQ-034 Reset, drive 0, hold 10 clocks -> update at clock 6, seg = 7'b1000000, digit_valid = 1, step_count = 0.
REQ-035 Step 0..9..0..1 each held 10 clocks -> step_count = 11, one wrap pulse on 9->0, err_seq = 0.
REQ-036 From 3, 2-clock glitch to 7 -> no update, seg stays 3's pattern.
REQ-037 From 4, apply 12 then 5 -> err_illegal = 1, seg dash then 5's pattern, err_seq = 0, step_count +1.
REQ-038 From 2, apply 6 -> err_seq = 1; err_clr with simultaneous jump 6->1 -> err_seq remains 1.
REQ-039 Drop rst_n 2 clocks after input change -> all outputs at reset values; acceptance after 6 clocks from release.

Source files
------------

// File: rtl/bcd_display_receiver_pkg.sv
// Shared constants for the BCD display receiver: seven-segment patterns (active-low,
// bit 0 = segment a) and the tracking FSM encoding.
package bcd_display_receiver_pkg;

  typedef enum logic [0:0] {
    StWaitFirst,
    StTrack
  } state_e;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SegDigits = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    if (code > 4'd9) begin
      return SegDash;
    end
    return SegDigits[code];
  endfunction

endpackage

// File: rtl/bcd_input_filter.sv
// Two-flop synchronizer plus stability filter: a synchronized code that holds for
// STABLE_CYCLES clocks and differs from the last accepted code is accepted.
module bcd_input_filter #(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code_in,
  output logic [3:0] code,
  output logic       accept
);

  localparam logic [15:0] Target = 16'(STABLE_CYCLES);

  logic [3:0]  sync1_q, sync2_q;
  logic [1:0]  fill_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  code_q;
  logic        accept_q, accept_d;
  logic        acc_valid_q;

  // fill_q keeps the counter from starting until sync2 holds a real sample, so
  // the first code after reset needs the same 2 + STABLE_CYCLES clocks as any other.
  always_comb begin
    cnt_d = cnt_q;
    if (!fill_q[0]) begin
      cnt_d = '0;
    end else if (!fill_q[1] || (sync1_q != sync2_q)) begin
      cnt_d = 16'd1;
    end else if (cnt_q != Target) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign accept_d = (cnt_d == Target) && (!acc_valid_q || (sync2_q != code_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      accept_q    <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      sync1_q  <= code_in;
      sync2_q  <= sync1_q;
      fill_q   <= {fill_q[0], 1'b1};
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      if (accept_d) begin
        code_q      <= sync2_q;
        acc_valid_q <= 1'b1;
      end
    end
  end

  assign code   = code_q;
  assign accept = accept_q;

endmodule

// File: rtl/bcd_display_receiver.sv
// Receives a BCD count from an asynchronous board, drives a seven-segment display and
// tracks whether successive digits arrive in counting order.
module bcd_display_receiver
  import bcd_display_receiver_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       err_clr,
  output logic [6:0] seg,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       update,
  output logic       wrap,
  output logic [7:0] step_count,
  output logic       err_illegal,
  output logic       err_seq
);

  logic [3:0] acc_code;
  logic       acc_stb;
  logic [3:0] next_digit;

  state_e     state_q;
  logic [6:0] seg_q;
  logic [3:0] digit_q;
  logic       digit_valid_q, update_q, wrap_q, err_illegal_q, err_seq_q;
  logic [7:0] step_q;

  bcd_input_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .code_in({D, C, B, A}),
    .code   (acc_code),
    .accept (acc_stb)
  );

  assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StWaitFirst;
      seg_q         <= SegBlank;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      update_q      <= 1'b0;
      wrap_q        <= 1'b0;
      step_q        <= '0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
    end else begin
      update_q      <= acc_stb;
      wrap_q        <= 1'b0;
      // Clear first; a set later in this block overrides it.
      err_illegal_q <= err_illegal_q & ~err_clr;
      err_seq_q     <= err_seq_q & ~err_clr;
      if (acc_stb) begin
        if (acc_code > 4'd9) begin
          seg_q         <= SegDash;
          err_illegal_q <= 1'b1;
        end else begin
          seg_q         <= seg_pattern(acc_code);
          digit_q       <= acc_code;
          digit_valid_q <= 1'b1;
          unique case (state_q)
            StWaitFirst: state_q <= StTrack;
            StTrack: begin
              if (acc_code == next_digit) begin
                step_q <= step_q + 8'd1;
                wrap_q <= (acc_code == 4'd0);
              end else begin
                err_seq_q <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  assign seg         = seg_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign update      = update_q;
  assign wrap        = wrap_q;
  assign step_count  = step_q;
  assign err_illegal = err_illegal_q;
  assign err_seq     = err_seq_q;

endmodule
